// File: rtl/md_pkg.sv
// md_pkg: op codes, FSM states and default width shared by md_unit and the decoder
package md_pkg;
  localparam int MD_WIDTH = 32;
  typedef enum logic [3:0] {
    OP_NOP, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO,
    OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU
  } op_t;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_ACC} state_t;
  function automatic logic is_signed(op_t op);
    return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
  endfunction
endpackage

// File: rtl/md_unit_if.sv
// md_unit_if: pipeline-side bus of md_unit (op issue, HI/LO read, stall)
interface md_unit_if #(parameter int WIDTH = md_pkg::MD_WIDTH);
  import md_pkg::*;
  logic start, rd_hilo, flush, stall, busy;
  op_t op;
  logic [WIDTH-1:0] src_a, src_b, hi, lo;
  modport master (output start, op, src_a, src_b, rd_hilo, flush, input stall, busy, hi, lo);
  modport slave (input start, op, src_a, src_b, rd_hilo, flush, output stall, busy, hi, lo);
endinterface

// File: rtl/md_div_core.sv
// md_div_core: radix-2 restoring divider on magnitudes, one bit per cycle, sign fixup while done
module md_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);
  localparam int SW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] q, r, d;
  logic [SW-1:0] step;
  logic run, neg_q, neg_r, ge;
  logic [WIDTH:0] sh;
  assign sh = {r, q[WIDTH-1]};
  assign ge = sh >= {1'b0, d};
  assign done = run & (step == SW'(WIDTH));
  assign quo = neg_q ? -q : q;
  assign rem = neg_r ? -r : r;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
      r <= '0;
      d <= '0;
      step <= '0;
      run <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (abort) begin
      run <= 1'b0;
    end else if (start) begin
      q <= (sgn & a[WIDTH-1]) ? -a : a;
      d <= (sgn & b[WIDTH-1]) ? -b : b;
      r <= '0;
      step <= '0;
      run <= 1'b1;
      // a zero divisor keeps the all-ones quotient unsigned
      neg_q <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]) & (|b);
      neg_r <= sgn & a[WIDTH-1];
    end else if (done) begin
      run <= 1'b0;
    end else if (run) begin
      step <= step + SW'(1);
      r <= ge ? WIDTH'(sh - {1'b0, d}) : sh[WIDTH-1:0];
      q <= {q[WIDTH-2:0], ge};
    end
  end
endmodule

// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit owning HI/LO, with flush and unified stall
// `MD_MADD_EN enables MADD/MADDU/MSUB/MSUBU accumulate into {hi,lo}
module md_unit import md_pkg::*; #(
  parameter int WIDTH   = MD_WIDTH,
  parameter int MUL_LAT = 3
) (
  input logic      clk,
  input logic      rst,
  md_unit_if.slave md
);
  localparam int CW = $clog2(WIDTH + 2);
  state_t state;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] pipe [MUL_LAT];
  logic [2*WIDTH-1:0] ext_a, ext_b;
  logic [WIDTH-1:0] hi, lo, quo, rem;
  logic busy, ok_op, is_acc, is_div, accept, acc_op, sub_op, div_done;
`ifdef MD_MADD_EN
  assign is_acc = md.op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
`else
  assign is_acc = 1'b0;
`endif
  assign ok_op = (md.op inside {[OP_MULT:OP_MTLO]}) | is_acc;
  assign is_div = md.op inside {OP_DIV, OP_DIVU};
  assign ext_a = is_signed(md.op) ? {{WIDTH{md.src_a[WIDTH-1]}}, md.src_a} : {{WIDTH{1'b0}}, md.src_a};
  assign ext_b = is_signed(md.op) ? {{WIDTH{md.src_b[WIDTH-1]}}, md.src_b} : {{WIDTH{1'b0}}, md.src_b};
  assign busy = state != S_IDLE;
  assign accept = md.start & ~busy & ~md.flush & ok_op;
  assign md.busy = busy;
  assign md.stall = busy & (md.start | md.rd_hilo);
  assign md.hi = hi;
  assign md.lo = lo;
  md_div_core #(.WIDTH(WIDTH)) u_div (
    .clk(clk), .rst(rst), .start(accept & is_div), .abort(md.flush), .sgn(is_signed(md.op)),
    .a(md.src_a), .b(md.src_b), .done(div_done), .quo(quo), .rem(rem)
  );
  // pipe[0] is loaded only at accept, so every stage settles to the same product
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      acc_op <= 1'b0;
      sub_op <= 1'b0;
      for (int i = 0; i < MUL_LAT; i++) pipe[i] <= '0;
    end else begin
      for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
      cnt <= cnt + CW'(busy && cnt != '1);
      if (accept) begin
        pipe[0] <= ext_a * ext_b;
        acc_op <= is_acc;
        sub_op <= md.op inside {OP_MSUB, OP_MSUBU};
        state <= (md.op inside {OP_MULT, OP_MULTU} || is_acc) ? S_MUL : is_div ? S_DIV : S_IDLE;
        if (md.op == OP_MTHI) hi <= md.src_a;
        if (md.op == OP_MTLO) lo <= md.src_a;
      end else if (md.flush) begin
        state <= S_IDLE;
        cnt <= '0;
      end else if (state == S_MUL && cnt == CW'(MUL_LAT - 1)) begin
        state <= acc_op ? S_ACC : S_IDLE;
        cnt <= acc_op ? cnt : '0;
        if (!acc_op) {hi, lo} <= pipe[MUL_LAT-1];
      end else if (state == S_ACC) begin
        state <= S_IDLE;
        cnt <= '0;
        {hi, lo} <= sub_op ? {hi, lo} - pipe[MUL_LAT-1] : {hi, lo} + pipe[MUL_LAT-1];
      end else if (state == S_DIV && div_done) begin
        state <= S_IDLE;
        cnt <= '0;
        {hi, lo} <= {rem, quo};
      end
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed vectors for md_unit (WIDTH=32, MUL_LAT=3), honours `MD_MADD_EN
module tb_md_unit;
  import md_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int c;
  md_unit_if #(.WIDTH(32)) bus();
  md_unit #(.WIDTH(32), .MUL_LAT(3)) dut (.clk(clk), .rst(rst), .md(bus.slave));
  always #5 clk = ~clk;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic issue(op_t o, logic [31:0] a, logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = o;
    bus.src_a = a;
    bus.src_b = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op = OP_NOP;
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.start = 1'b0;
    bus.op = OP_NOP;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.rd_hilo = 1'b0;
    bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_stall", bus.stall, 0);
    rst = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = OP_MULT;
    bus.src_a = 32'hFFFFFFFD;
    bus.src_b = 32'd7;
    #1 check("accept_stall", bus.stall, 0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op = OP_NOP;
    bus.src_a = 32'd9;
    bus.src_b = 32'd9;
    wait_idle(c);
    check("mult_lat", c, 3);
    check("mult_hi", bus.hi, 32'hFFFFFFFF);
    check("mult_lo", bus.lo, 32'hFFFFFFEB);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle(c);
    check("multu_hi", bus.hi, 32'hFFFFFFFE);
    check("multu_lo", bus.lo, 32'h00000001);
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle(c);
    check("div_lat", c, 33);
    check("div_lo", bus.lo, 32'hFFFFFFFD);
    check("div_hi", bus.hi, 32'hFFFFFFFF);
    issue(OP_DIVU, 32'd7, 32'd0);
    wait_idle(c);
    check("div0_lo", bus.lo, 32'hFFFFFFFF);
    check("div0_hi", bus.hi, 32'd7);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(c);
    check("ovf_lo", bus.lo, 32'h80000000);
    check("ovf_hi", bus.hi, 32'd0);
    issue(OP_MTHI, 32'h1234, 32'd0);
    check("mthi_busy", bus.busy, 0);
    check("mthi_hi", bus.hi, 32'h1234);
    issue(OP_MTLO, 32'h5678, 32'd0);
    check("mtlo_lo", bus.lo, 32'h5678);
    issue(OP_DIV, 32'd100, 32'd7);
    @(negedge clk);
    bus.rd_hilo = 1'b1;
    bus.start = 1'b1;
    bus.op = OP_MULTU;
    bus.src_a = 32'd3;
    bus.src_b = 32'd5;
    #1;
    c = 0;
    while (bus.stall && c < 100) begin
      c++;
      @(negedge clk);
      #1;
    end
    check("stall_len", c, 32);
    check("stall_lo", bus.lo, 32'd14);
    check("stall_hi", bus.hi, 32'd2);
    @(negedge clk);
    bus.start = 1'b0;
    bus.rd_hilo = 1'b0;
    bus.op = OP_NOP;
    check("second_busy", bus.busy, 1);
    wait_idle(c);
    check("second_lo", bus.lo, 32'd15);
    check("second_hi", bus.hi, 32'd0);
    issue(OP_DIV, 32'd50, 32'd3);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", bus.busy, 0);
    check("flush_hi", bus.hi, 32'd0);
    check("flush_lo", bus.lo, 32'd15);
    bus.flush = 1'b1;
    bus.start = 1'b1;
    bus.op = OP_MULT;
    bus.src_a = 32'd2;
    bus.src_b = 32'd2;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.start = 1'b0;
    bus.op = OP_NOP;
    check("flush_start_busy", bus.busy, 0);
    repeat (40) @(negedge clk);
    check("flush_start_lo", bus.lo, 32'd15);
    issue(OP_MULT, 32'd5, 32'd5);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_lo", bus.lo, 0);
    check("rst_mid_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    issue(OP_MTLO, 32'd5, 32'd0);
    issue(OP_MADD, 32'd2, 32'd3);
    wait_idle(c);
`ifdef MD_MADD_EN
    check("madd_lat", c, 4);
    check("madd_lo", bus.lo, 32'd11);
    check("madd_hi", bus.hi, 32'd0);
    issue(OP_MSUBU, 32'd1, 32'd12);
    wait_idle(c);
    check("msubu_hi", bus.hi, 32'hFFFFFFFF);
    check("msubu_lo", bus.lo, 32'hFFFFFFFF);
`else
    check("madd_lat", c, 0);
    check("madd_lo", bus.lo, 32'd5);
    check("madd_hi", bus.hi, 32'd0);
    issue(OP_MSUBU, 32'd1, 32'd12);
    wait_idle(c);
    check("msubu_hi", bus.hi, 32'd0);
    check("msubu_lo", bus.lo, 32'd5);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
